// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the writeback scheduler slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package regfile_pkg;

  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // x0 is hardwired: never written, never busy.
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, ascending with wrap.
// Latency: grant is combinational; pointer moves at the edge of a completed handshake.
// Backpressure: pointer holds when adv_i is low, so an unaccepted winner stays first in line.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req_i,
  input  logic                 adv_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] winner_o
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Pick the first requester at or after the pointer, wrapping at N.
  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr_q) + k) % N);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o     = idx;
      end
    end
  end

  // After a transfer the winner's successor gets first priority.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (int'(winner_o) == N - 1) ? '0 : winner_o + IDX_W'(1);
    end
  end

  // Pointer register, synchronous reset to requester 0.
  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: round-robin over writeback sources plus a busy scoreboard.
// Latency: accepted request appears on rf_write_* one cycle later; busy clears on that commit edge.
// Backpressure: one req_ready per cycle; issue_ready drops while the destination is still pending.
module regfile_wb_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  output logic                      issue_ready,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [(1<<ADDR_W)-1:0]    busy_vec
);
  import regfile_pkg::*;

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [NUM_REQ-1:0]         grant;
  logic [$clog2(NUM_REQ)-1:0] win;
  logic                       xfer;
  logic [ADDR_W-1:0]          sel_addr;
  logic [DATA_W-1:0]          sel_data;

  logic                       we_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [DATA_W-1:0]          data_q;

  logic [NREGS-1:0]           busy_q, busy_d;
  logic                       issue_fire;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (req_valid),
    .adv_i    (xfer),
    .grant_o  (grant),
    .winner_o (win)
  );

  // Nobody is accepted while reset is held.
  assign req_ready = reset_n ? grant : '0;
  assign xfer      = |(req_valid & req_ready);
  assign sel_addr  = req_addr[int'(win)*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[int'(win)*DATA_W +: DATA_W];

  // Register the accepted write; a write to x0 is consumed without a strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= xfer && (sel_addr != ZERO_A);
      if (xfer) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
      end
    end
  end

  assign rf_write_enable = we_q;
  assign rf_write_addr   = addr_q;
  assign rf_write_data   = data_q;

  // A pending destination blocks a second reservation until its write commits.
  assign issue_ready = reset_n && ((issue_rd == ZERO_A) || !busy_q[issue_rd]);
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != ZERO_A);

  // Clear on commit, set on reservation; the two never target the same register.
  always_comb begin
    busy_d = busy_q;
    if (we_q)       busy_d[addr_q]   = 1'b0;
    if (issue_fire) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register, synchronous reset drops all reservations.
  always_ff @(posedge clk) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios then randomized traffic vs a reference model.
// Latency: model expects rf_write_* one cycle after accept.
// Backpressure: requesters hold valid/addr/data until granted.
module tb_regfile_wb_scheduler;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int NREGS   = 32;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      rf_write_enable;
  logic [ADDR_W-1:0]         rf_write_addr;
  logic [DATA_W-1:0]         rf_write_data;
  logic                      issue_valid;
  logic [ADDR_W-1:0]         issue_rd;
  logic                      issue_ready;
  logic [ADDR_W-1:0]         rs1_addr;
  logic [ADDR_W-1:0]         rs2_addr;
  logic                      rs1_busy;
  logic                      rs2_busy;
  logic [NREGS-1:0]          busy_vec;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .issue_valid     (issue_valid),
    .issue_rd        (issue_rd),
    .issue_ready     (issue_ready),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rs1_busy        (rs1_busy),
    .rs2_busy        (rs2_busy),
    .busy_vec        (busy_vec)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  bit [NREGS-1:0] m_busy;
  int             m_ptr;
  bit             m_we;
  logic [4:0]     m_waddr;
  logic [31:0]    m_wdata;
  bit             hold [NUM_REQ];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_winner();
    if (!reset_n) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit exp_issue_ready();
    if (!reset_n) return 1'b0;
    return (issue_rd == 5'd0) || !m_busy[issue_rd];
  endfunction

  task automatic check_outputs();
    int w;
    logic [NUM_REQ-1:0] er;
    w  = pick_winner();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready",   64'(req_ready),   64'(er));
    chk("issue_ready", 64'(issue_ready), 64'(exp_issue_ready()));
    chk("rs1_busy",    64'(rs1_busy),    64'((rs1_addr != 0) && m_busy[rs1_addr]));
    chk("rs2_busy",    64'(rs2_busy),    64'((rs2_addr != 0) && m_busy[rs2_addr]));
    chk("busy_vec",    64'(busy_vec),    64'(m_busy));
    chk("rf_we",       64'(rf_write_enable), 64'(m_we));
    if (m_we) begin
      chk("rf_addr", 64'(rf_write_addr), 64'(m_waddr));
      chk("rf_data", 64'(rf_write_data), 64'(m_wdata));
    end
  endtask

  // Apply the spec's edge rules to the model using the inputs present at this edge.
  task automatic model_update();
    int w;
    bit ir;
    bit [NREGS-1:0] nb;
    w  = pick_winner();
    ir = exp_issue_ready();
    if (!reset_n) begin
      m_busy  = '0;
      m_ptr   = 0;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      foreach (hold[i]) hold[i] = 1'b0;
      return;
    end
    nb = m_busy;
    if (m_we) nb[m_waddr] = 1'b0;
    if (issue_valid && ir && issue_rd != 0) nb[issue_rd] = 1'b1;
    m_busy = nb;
    for (int i = 0; i < NUM_REQ; i++) hold[i] = req_valid[i] && (i != w);
    if (w >= 0) begin
      m_waddr = req_addr[w*ADDR_W +: ADDR_W];
      m_wdata = req_data[w*DATA_W +: DATA_W];
      m_we    = (m_waddr != 0);
      m_ptr   = (w + 1) % NUM_REQ;
    end else begin
      m_we = 1'b0;
    end
  endtask

  // Inputs are set at the falling edge; outputs checked 1ns later; model steps at the rising edge.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic drive_random();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hold[i]) begin
        req_valid[i] = ($urandom_range(0, 2) != 0);
        set_req(i, 5'($urandom_range(0, 15)), $urandom());
      end
    end
    issue_valid = 1'($urandom_range(0, 1));
    issue_rd    = 5'($urandom_range(0, 15));
    rs1_addr    = 5'($urandom_range(0, 15));
    rs2_addr    = 5'($urandom_range(0, 15));
    reset_n     = ($urandom_range(0, 199) != 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
    m_busy = '0; m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    foreach (hold[i]) hold[i] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset: nothing accepted even with everything asserted.
    req_valid = 3'b111; issue_valid = 1'b1; issue_rd = 5'd5;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_issue", 64'(issue_ready), 64'(0));
    chk("rst_we",    64'(rf_write_enable), 64'(0));
    chk("rst_busy",  64'(busy_vec), 64'(0));
    tick();

    // Single write, one-cycle latency.
    reset_n = 1'b1; issue_valid = 1'b0;
    req_valid = 3'b001; set_req(0, 5'd5, 32'hDEADBEEF);
    #1; chk("t1_ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
    #1;
    chk("t1_we",   64'(rf_write_enable), 64'(1));
    chk("t1_addr", 64'(rf_write_addr), 64'(5));
    chk("t1_data", 64'(rf_write_data), 64'(32'hDEADBEEF));
    tick();
    #1; chk("t1_we_off", 64'(rf_write_enable), 64'(0));
    tick();

    // Round robin from a fresh pointer: 0,1,2,0.
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
    for (int k = 0; k < 4; k++) begin
      #1; chk("t2_grant", 64'(req_ready), 64'(1 << (k % 3)));
      if (k > 0) chk("t2_we", 64'(rf_write_enable), 64'(1));
      tick();
    end
    req_valid = '0;

    // Reserve x7, stall a second reservation, clear on commit.
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1; chk("t3_issue1", 64'(issue_ready), 64'(1));
    tick();
    rs1_addr = 5'd7;
    #1;
    chk("t3_busy7", 64'(busy_vec[7]), 64'(1));
    chk("t3_rs1",   64'(rs1_busy), 64'(1));
    chk("t3_stall", 64'(issue_ready), 64'(0));
    tick();
    issue_valid = 1'b0; req_valid = 3'b010; set_req(1, 5'd7, 32'h12345678);
    #1; chk("t3_ready1", 64'(req_ready), 64'(3'b010));
    tick();
    req_valid = '0; issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    chk("t3_we",      64'(rf_write_enable), 64'(1));
    chk("t3_still",   64'(busy_vec[7]), 64'(1));
    chk("t3_stall2",  64'(issue_ready), 64'(0));
    tick();
    #1;
    chk("t3_clr",    64'(busy_vec[7]), 64'(0));
    chk("t3_reissue", 64'(issue_ready), 64'(1));
    tick();

    // x0: reservation and write are accepted but have no effect.
    issue_rd = 5'd0; rs2_addr = 5'd0;
    req_valid = 3'b001; set_req(0, 5'd0, 32'hCAFE0000);
    #1;
    chk("t4_issue0", 64'(issue_ready), 64'(1));
    chk("t4_ready0", 64'(req_ready), 64'(3'b001));
    chk("t4_rs2",    64'(rs2_busy), 64'(0));
    tick();
    issue_valid = 1'b0; req_valid = '0;
    #1;
    chk("t4_we0",  64'(rf_write_enable), 64'(0));
    chk("t4_busy", 64'(busy_vec), 64'(32'h0000_0080));
    tick();

    // Set x4 while the write to busy x9 commits.
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0; req_valid = 3'b100; set_req(2, 5'd9, 32'h99);
    #1; chk("t5_ready2", 64'(req_ready), 64'(3'b100));
    tick();
    req_valid = '0; issue_valid = 1'b1; issue_rd = 5'd4;
    #1; chk("t5_commit", 64'(rf_write_addr), 64'(9));
    tick();
    issue_valid = 1'b0;
    #1; chk("t5_busy", 64'(busy_vec), 64'(32'h0000_0090));
    tick();

    // Reset with a write in flight: write dropped, scoreboard and pointer cleared.
    issue_valid = 1'b1; issue_rd = 5'd3;
    req_valid = 3'b001; set_req(0, 5'd3, 32'h33);
    #1; chk("t6_ready", 64'(req_ready), 64'(3'b001));
    tick();
    issue_valid = 1'b0; reset_n = 1'b0;
    req_valid = 3'b101; set_req(2, 5'd6, 32'h66);
    #1; chk("t6_inflight", 64'(rf_write_enable), 64'(1));
    tick();
    reset_n = 1'b1;
    #1;
    chk("t6_we",    64'(rf_write_enable), 64'(0));
    chk("t6_waddr", 64'(rf_write_addr), 64'(0));
    chk("t6_busy",  64'(busy_vec), 64'(0));
    chk("t6_ptr",   64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Shares the register file's single synchronous write port among NUM_REQ writeback sources (ALU, load unit, CSR unit) using round-robin arbitration with valid/ready handshakes.
Also keeps a 32-entry busy scoreboard. The issue stage marks a destination register pending; the scheduler clears it when the write commits.
Issue logic queries the scoreboard for rs1/rs2 hazards. The block sits between the execute/writeback units and the register file's write port.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-requester write request valid
req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero
req_addr  in  NUM_REQ*ADDR_W  packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
rf_write_enable  out  1  to register file write_enable
rf_write_addr  out  ADDR_W  to register file write_addr
rf_write_data  out  DATA_W  to register file write_data
issue_valid  in  1  issue stage wants to reserve a destination register
issue_rd  in  ADDR_W  destination register to reserve
issue_ready  out  1  reservation accepted this cycle
rs1_addr  in  ADDR_W  hazard query address 1
rs2_addr  in  ADDR_W  hazard query address 2
rs1_busy  out  1  rs1 has a pending write
rs2_busy  out  1  rs2 has a pending write
busy_vec  out  2**ADDR_W  raw scoreboard, bit 0 always 0

Behaviour:
- Reset values, applied on a clk edge with reset_n=0:
  - rf_write_enable=0, rf_write_addr=0, rf_write_data=0
  - busy_vec=0, RR pointer=0
  - req_ready=0 and issue_ready=0 while reset_n=0
- Arbitration (combinational):
  - Search starts at the RR pointer, ascending with wrap.
  - The first i with req_valid[i]=1 wins, and req_ready[i]=1 in the same cycle.
  - Handshake: a transfer occurs when valid and ready are both 1. Requesters hold valid/addr/data stable until ready.
  - On a transfer the pointer becomes (winner+1) mod NUM_REQ. With no transfer the pointer holds.
- Write path:
  - Latency is one cycle. The accepted addr/data are registered into rf_write_* at the accept edge.
  - rf_write_enable=1 for exactly one cycle per accepted request. The register file commits at the following edge.
  - Back-to-back accepts give one write per cycle at full throughput.
  - A request with addr 0 is accepted (ready=1) but produces rf_write_enable=0.
- Scoreboard:
  - Set: busy[issue_rd] is set at an edge where issue_valid && issue_ready && issue_rd!=0.
  - issue_ready = !busy[issue_rd], or 1 when issue_rd=0. A second writer to a pending register is stalled.
  - Clear: busy[rf_write_addr] is cleared at an edge where rf_write_enable=1. This is the same edge the register file commits the data.
  - Writing a non-busy register is legal and does not change the scoreboard.
  - Set and clear of the same register in one cycle is impossible: issue_ready=0 while the register is busy.
  - Set and clear of different registers in one cycle: both take effect.
- Queries:
  - rs1_busy = busy[rs1_addr] and rs2_busy = busy[rs2_addr], combinational from registered state.
  - Address 0 always reads as not busy.
- reset_n deasserted mid-operation:
  - Any in-flight registered write is dropped and all busy bits clear.
  - Requesters must re-present their requests after reset.

Decomposition:
- Package regfile_pkg:
  - REG_COUNT=32, ADDR_W, DATA_W
  - typedefs reg_addr_t and reg_data_t
  - constant REG_ZERO
- Sub-module rr_arbiter (parameter N):
  - inputs: request vector, handshake-advance strobe
  - outputs: one-hot grant, winner index
  - owns the RR pointer

Test Plan:
1. After reset: rf_write_enable=0, busy_vec=0, req_ready=0 during reset. Then req0 valid addr=5 data=0xDEADBEEF -> ready0=1 at cycle 0; cycle 1 rf_write_enable=1, addr=5, data=0xDEADBEEF; cycle 2 enable=0.
2. All three requesters valid continuously (addrs 1/2/3) -> grants 0,1,2,0 on consecutive cycles, exactly one ready per cycle, one write per cycle.
3. Issue rd=7 -> busy_vec[7]=1 and rs1_addr=7 gives rs1_busy=1. A second issue to rd=7 sees issue_ready=0. Req1 writes addr 7 -> busy[7] clears on the edge where rf_write_enable=1, and issue rd=7 is accepted the next cycle.
4. Issue rd=0 -> issue_ready=1, busy_vec unchanged. Request addr=0 -> ready=1, rf_write_enable stays 0. rs2_addr=0 -> rs2_busy=0.
5. Same cycle: issue rd=4 while the write to busy rd=9 commits -> busy[4]=1 and busy[9]=0 after the edge.
6. Issue rd=3 and accept a write to 3, then assert reset_n=0 at the next edge -> rf_write_enable=0, busy_vec=0, RR pointer back to 0 (req2 and req0 both valid gives grant to 0).
